hilo_register_unit: RTL and testbench
=====================================

// Module: hilo_register_unit
// PURPOSE
//  Downstream consumer of the iterative multiplier. It tracks an in-flight MULTU and captures the
//  64-bit product into the HI/LO architectural registers once the product is final.
//  It serves MFHI/MFLO/MTHI/MTLO from the EX stage and raises a pipeline stall when a HI/LO
//  instruction arrives while a multiply is still in flight.
// PARAMETERS
//  MUL_LATENCY  33  cycles from MULTU acceptance until multiplier dataout is final (1 start + 32 iterations)
//  CNT_W        6   width of latency counter; must satisfy 2**CNT_W > MUL_LATENCY
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high; clears all state immediately
//  instr_valid  in   1   EX-stage instruction valid this cycle
//  funct        in   6   R-type funct of EX instruction (same bus that drives the multiplier's Signal)
//  rs_data      in   32  source operand for MTHI/MTLO
//  product      in   64  multiplier dataout
//  hilo_rdata   out  32  MFHI -> HI, MFLO -> LO, otherwise 0 (combinational)
//  stall        out  1   freeze PC/IF/ID/EX; instruction must be re-presented unchanged (combinational)
//  mul_busy     out  1   multiply in flight (registered)
//  mul_done     out  1   one-cycle pulse in the cycle after HI/LO capture (registered)
//  hi_out       out  32  current HI
//  lo_out       out  32  current LO
// BEHAVIOUR
//  Reset values: hi=0, lo=0, state=IDLE, cnt=0, mul_busy=0, mul_done=0.
//  - stall=0 and hilo_rdata=0 while reset is asserted.
//  - Reset during BUSY abandons the multiply. No capture occurs.
//  funct codes: MULTU=6'b011001, MFHI=6'b010000, MTHI=6'b010001, MFLO=6'b010010, MTLO=6'b010011.
//  hilo_op = instr_valid && funct in {MULTU, MFHI, MTHI, MFLO, MTLO}.
//  FSM states: IDLE, BUSY.
//   IDLE: on an edge with instr_valid && funct==MULTU, load cnt=MUL_LATENCY, go BUSY, set mul_busy=1.
//   BUSY: each edge, if cnt!=0 then decrement cnt.
//     When cnt==0 (the capture edge):
//       - hi<=product[63:32], lo<=product[31:0]
//       - go IDLE; mul_busy=0, mul_done=1 for the next cycle
//     Capture therefore occurs MUL_LATENCY+1 edges after acceptance.
//  stall = (state==BUSY) && hilo_op.
//   - This covers a back-to-back MULTU, which is accepted on the first IDLE edge.
//  MTHI/MTLO: hi or lo <= rs_data on the edge when not stalled.
//  MFHI/MFLO: hilo_rdata is valid whenever stall=0.
//  Simultaneous events: none possible. Capture happens only in BUSY, and every HI/LO write is
//  stalled in BUSY. Non-HI/LO instructions never stall and flow freely during BUSY.
//  A MULTU asserted while instr_valid=0 is ignored.
// CONFIGURATION
//  HILO_FORWARD_EN defined:
//   - On the capture cycle (BUSY && cnt==0), MFHI/MFLO are not stalled.
//   - hilo_rdata is forwarded from product[63:32] or product[31:0].
//   - Saves one stall cycle.
//   - MTHI/MTLO/MULTU still stall on the capture cycle.
//  HILO_FORWARD_EN undefined: the capture cycle stalls like every other BUSY cycle.
// STRUCTURE
//  hilo_pkg:
//   - funct localparams (FUNCT_MULTU, FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO)
//   - state encoding (ST_IDLE, ST_BUSY)
//   - default MUL_LATENCY
//  One sub-module: hilo_busy_fsm (state, cnt, mul_busy, mul_done, capture strobe).
//  The top level holds the HI/LO registers, read mux, stall logic and forwarding.
// TESTING
//  1 Reset: assert reset mid-cycle -> hi_out=lo_out=0, stall=0, mul_busy=0 without a clock edge.
//  2 MULTU, product model = 0xFFFFFFFF*0xFFFFFFFF:
//    - mul_busy rises after edge 0; capture at edge 34
//    - hi_out=0xFFFFFFFE, lo_out=0x00000001; mul_done high for exactly 1 cycle
//  3 MULTU then MFLO next cycle:
//    - stall=1 for 34 cycles (33 with HILO_FORWARD_EN)
//    - then hilo_rdata=product[31:0], stall=0
//  4 MTHI rs_data=0xDEADBEEF in IDLE -> hi_out=0xDEADBEEF next cycle.
//    Same op during BUSY -> stalled; hi is unchanged until IDLE.
//  5 Reset asserted at cnt=10 during BUSY -> IDLE, hi/lo=0, no mul_done.
//    A new MULTU is then accepted normally.
//  6 Non-HI/LO funct (ADD 6'b100000) during BUSY -> stall=0 every cycle.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register unit: R-type funct codes, busy-FSM state
// encoding and the default multiplier latency.
package hilo_pkg;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    localparam int MUL_LATENCY_DEF = 33;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_hilo_funct(input logic [5:0] f);
        return (f == FUNCT_MULTU) || (f == FUNCT_MFHI) || (f == FUNCT_MTHI) ||
               (f == FUNCT_MFLO)  || (f == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/hilo_busy_fsm.sv
// Tracks an in-flight MULTU: counts the multiplier latency and flags the capture cycle,
// after which it returns to IDLE and pulses mul_done for one cycle.
module hilo_busy_fsm
    import hilo_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic cap_cycle,
    output logic mul_busy,
    output logic mul_done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(MUL_LATENCY);
                end
            end
            ST_BUSY: begin
                // cnt==0 is the capture edge; the product is final only from then on
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q == ST_BUSY);
    assign cap_cycle = (state_q == ST_BUSY) && (cnt_q == '0);
    assign mul_busy  = busy;
    assign mul_done  = done_q;

endmodule

// File: rtl/hilo_register_unit.sv
// HI/LO architectural registers behind the iterative multiplier, with MFHI/MFLO read mux
// and EX-stage stall. Define HILO_FORWARD_EN to forward the product on the capture cycle.
module hilo_register_unit
    import hilo_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [63:0] product,
    output logic [31:0] hilo_rdata,
    output logic        stall,
    output logic        mul_busy,
    output logic        mul_done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        is_multu, is_mfhi, is_mthi, is_mflo, is_mtlo, hilo_op;
    logic        busy, cap_cycle, fwd_read, start;

    assign is_multu = instr_valid && (funct == FUNCT_MULTU);
    assign is_mfhi  = instr_valid && (funct == FUNCT_MFHI);
    assign is_mthi  = instr_valid && (funct == FUNCT_MTHI);
    assign is_mflo  = instr_valid && (funct == FUNCT_MFLO);
    assign is_mtlo  = instr_valid && (funct == FUNCT_MTLO);
    assign hilo_op  = instr_valid && is_hilo_funct(funct);

`ifdef HILO_FORWARD_EN
    assign fwd_read = cap_cycle && (is_mfhi || is_mflo);
`else
    assign fwd_read = 1'b0;
`endif

    assign stall = !reset && busy && hilo_op && !fwd_read;
    assign start = is_multu && !stall;

    hilo_busy_fsm #(
        .MUL_LATENCY (MUL_LATENCY),
        .CNT_W       (CNT_W)
    ) u_busy_fsm (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .cap_cycle (cap_cycle),
        .mul_busy  (mul_busy),
        .mul_done  (mul_done)
    );

    // Capture and MTHI/MTLO can never coincide: every HI/LO write stalls while busy
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (cap_cycle) begin
            hi_d = product[63:32];
            lo_d = product[31:0];
        end else if (!stall) begin
            if (is_mthi) hi_d = rs_data;
            if (is_mtlo) lo_d = rs_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        hilo_rdata = '0;
        if (!reset) begin
            if (is_mfhi)      hilo_rdata = fwd_read ? product[63:32] : hi_q;
            else if (is_mflo) hilo_rdata = fwd_read ? product[31:0]  : lo_q;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_register_unit.sv
// Randomized bench for hilo_register_unit against a capture-time reference model.
module tb_hilo_register_unit;
    import hilo_pkg::*;

    localparam int LAT = 33;
`ifdef HILO_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [63:0] product;
    logic [31:0] hilo_rdata;
    logic        stall, mul_busy, mul_done;
    logic [31:0] hi_out, lo_out;

    hilo_register_unit #(
        .MUL_LATENCY (LAT),
        .CNT_W       (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .funct       (funct),
        .rs_data     (rs_data),
        .product     (product),
        .hilo_rdata  (hilo_rdata),
        .stall       (stall),
        .mul_busy    (mul_busy),
        .mul_done    (mul_done),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          edge_n   = 0;
    int          cap_edge = -1;   // edge number at which the pending product is captured
    logic [63:0] m_prod   = '0;
    logic [63:0] next_prod = '0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_done = 1'b0;
    logic        obs_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive after the edge, check at the falling edge, advance the model.
    task automatic step(input logic v, input logic [5:0] f, input logic [31:0] rs);
        logic        busy, capcyc, is_rd, e_stall;
        logic [31:0] e_rdata;
        busy   = (cap_edge >= 0);
        capcyc = busy && (edge_n == cap_edge);
        instr_valid = v;
        funct       = f;
        rs_data     = rs;
        product     = capcyc ? m_prod : {$urandom(), $urandom()};
        is_rd   = v && (f == FUNCT_MFHI || f == FUNCT_MFLO);
        e_stall = busy && v &&
                  (f inside {FUNCT_MULTU, FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO}) &&
                  !(FWD && capcyc && is_rd);
        e_rdata = '0;
        if (v && f == FUNCT_MFHI) e_rdata = (FWD && capcyc) ? m_prod[63:32] : m_hi;
        if (v && f == FUNCT_MFLO) e_rdata = (FWD && capcyc) ? m_prod[31:0]  : m_lo;

        @(negedge clk);
        obs_stall = stall;
        check("stall", 64'(stall), 64'(e_stall));
        if (!e_stall) check("rdata", 64'(hilo_rdata), 64'(e_rdata));
        check("mul_busy", 64'(mul_busy), 64'(busy));
        check("mul_done", 64'(mul_done), 64'(m_done));
        check("hi", 64'(hi_out), 64'(m_hi));
        check("lo", 64'(lo_out), 64'(m_lo));

        @(posedge clk);
        m_done = 1'b0;
        if (capcyc) begin
            m_hi     = m_prod[63:32];
            m_lo     = m_prod[31:0];
            cap_edge = -1;
            m_done   = 1'b1;
        end else if (v && !e_stall) begin
            if (f == FUNCT_MULTU) begin
                cap_edge = edge_n + LAT + 1;
                m_prod   = next_prod;
            end
            if (f == FUNCT_MTHI) m_hi = rs;
            if (f == FUNCT_MTLO) m_lo = rs;
        end
        edge_n++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 32'd0);
    endtask

    // Asserts reset between clock edges and checks the cleared state before any edge.
    task automatic reset_now(input string tag);
        reset       = 1'b1;
        instr_valid = 1'b1;
        funct       = FUNCT_MFHI;
        cap_edge    = -1;
        m_hi        = '0;
        m_lo        = '0;
        m_done      = 1'b0;
        #2;
        check({tag, "_hi"},    64'(hi_out),     64'd0);
        check({tag, "_lo"},    64'(lo_out),     64'd0);
        check({tag, "_stall"}, 64'(stall),      64'd0);
        check({tag, "_rdata"}, 64'(hilo_rdata), 64'd0);
        check({tag, "_busy"},  64'(mul_busy),   64'd0);
        check({tag, "_done"},  64'(mul_done),   64'd0);
        instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_stall;
        logic [5:0] rf;
        instr_valid = 1'b0;
        funct       = '0;
        rs_data     = '0;
        product     = '0;
        reset_now("rst0");

        // Worst-case unsigned operands
        next_prod = 64'(32'hFFFF_FFFF) * 64'(32'hFFFF_FFFF);
        step(1'b1, FUNCT_MULTU, 32'd0);
        idle(LAT + 3);
        check("t2_hi", 64'(hi_out), 64'h0000_0000_FFFF_FFFE);
        check("t2_lo", 64'(lo_out), 64'h0000_0000_0000_0001);

        // MULTU then MFLO held until released
        next_prod = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
        step(1'b1, FUNCT_MULTU, 32'd0);
        n_stall = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, FUNCT_MFLO, 32'd0);
            if (!obs_stall) break;
            n_stall++;
        end
        check("t3_stall_cycles", 64'(n_stall), FWD ? 64'd33 : 64'd34);
        idle(2);

        // MTHI in IDLE, then MTHI blocked during a multiply
        step(1'b1, FUNCT_MTHI, 32'hDEAD_BEEF);
        check("t4_mthi", 64'(hi_out), 64'h0000_0000_DEAD_BEEF);
        next_prod = 64'(32'h0000_0003) * 64'(32'h0000_0005);
        step(1'b1, FUNCT_MULTU, 32'd0);
        for (int i = 0; i < 10; i++) step(1'b1, FUNCT_MTHI, 32'h1234_5678);
        check("t4_hi_held", 64'(hi_out), 64'h0000_0000_DEAD_BEEF);
        idle(LAT);
        step(1'b1, FUNCT_MTHI, 32'h1234_5678);

        // Reset at cnt==10 abandons the multiply
        next_prod = 64'hAAAA_BBBB_CCCC_DDDD;
        step(1'b1, FUNCT_MULTU, 32'd0);
        idle(LAT - 10);
        reset_now("t5");
        idle(LAT + 4);
        next_prod = 64'(32'hCAFE_F00D) * 64'(32'h0000_1001);
        step(1'b1, FUNCT_MULTU, 32'd0);
        idle(LAT + 3);

        // Non-HI/LO instructions flow during a multiply
        next_prod = 64'(32'h8000_0000) * 64'(32'h0000_0002);
        step(1'b1, FUNCT_MULTU, 32'd0);
        for (int i = 0; i < 12; i++) step(1'b1, FUNCT_ADD, $urandom());
        idle(LAT);

        // Random instruction mix
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    rf = FUNCT_MULTU;
                2:       rf = FUNCT_MFHI;
                3:       rf = FUNCT_MFLO;
                4:       rf = FUNCT_MTHI;
                5:       rf = FUNCT_MTLO;
                6:       rf = FUNCT_ADD;
                default: rf = 6'($urandom());
            endcase
            next_prod = 64'($urandom()) * 64'($urandom());
            step($urandom_range(0, 3) != 0, rf, $urandom());
        end
        idle(LAT + 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
